m_illegalop_trap: RTL

Registered illegal-instruction detector with trap capture for the midgetv core. It decodes one 32-bit instruction per accepted handshake at a selectable decode strictness and optional RV32M support. It also captures the first offending instruction word (mtval source) and holds a trap request until the microcode sequencer acknowledges it. It keeps a saturating count of trapped instructions. It sits between instruction fetch and the microcode sequencer.

---
 rtl/m_illegalop_trap.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/m_illegalop_trap.sv
// rtl/m_illegalop_trap.sv - illegal-instruction detector with trap capture and saturating trap count
module m_illegalop_trap #(
    parameter int LAZY_DECODE = 0,
    parameter int MULDIV      = 0,
    parameter int PIPE        = 0,
    parameter int CNTW        = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     INSTR,
    input  logic            instr_valid,
    input  logic            corerunning,
    input  logic            trap_ack,
    output logic            ready,
    output logic            illegal,
    output logic            trap_pending,
    output logic [31:0]     trap_instr,
    output logic [CNTW-1:0] illegal_count,
    output logic            count_ovf
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic        op_known;
    logic        fields_ok;
    logic        dec_bad;
    logic        accept;
    logic        fire;
    logic [31:0] fire_word;
    logic        unused_bits;

    assign opcode      = INSTR[6:0];
    assign rd          = INSTR[11:7];
    assign funct3      = INSTR[14:12];
    assign rs1         = INSTR[19:15];
    assign funct7      = INSTR[31:25];
    assign unused_bits = ^INSTR[24:20];

    // opcode includes INSTR[1:0], so every known major opcode implies the 11 suffix
    always_comb begin
        op_known  = 1'b1;
        fields_ok = 1'b0;
        case (opcode)
            OP_LOAD:   fields_ok = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            OP_FENCE:  fields_ok = (funct3 == 3'b000) || (funct3 == 3'b001);
            OP_IMM: begin
                if (funct3 == 3'b001)
                    fields_ok = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101)
                    fields_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else
                    fields_ok = 1'b1;
            end
            OP_AUIPC:  fields_ok = 1'b1;
            OP_LUI:    fields_ok = 1'b1;
            OP_JAL:    fields_ok = 1'b1;
            OP_STORE:  fields_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            OP_OP: begin
                if (funct7 == 7'b0000000)
                    fields_ok = 1'b1;
                else if (funct7 == 7'b0100000)
                    fields_ok = (funct3 == 3'b000) || (funct3 == 3'b101);
                else if (funct7 == 7'b0000001)
                    fields_ok = (MULDIV != 0);
                else
                    fields_ok = 1'b0;
            end
            OP_BRANCH: fields_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
            OP_JALR:   fields_ok = (funct3 == 3'b000);
            OP_SYSTEM: begin
                if (funct3 == 3'b100)
                    fields_ok = 1'b0;
                else if (funct3 == 3'b000)
                    fields_ok = (rs1 == 5'd0) && (rd == 5'd0);
                else
                    fields_ok = 1'b1;
            end
            default:   op_known = 1'b0;
        endcase
    end

    always_comb begin
        dec_bad = ~(op_known & fields_ok);
        if (LAZY_DECODE == 2)
            dec_bad = ~INSTR[0];
        else if (LAZY_DECODE == 1)
            dec_bad = ~op_known;
    end

    assign accept = instr_valid & ready & corerunning;

    generate
        if (PIPE != 0) begin : g_pipe
            logic        s1_valid;
            logic        s1_bad;
            logic [31:0] s1_instr;

            // A younger instruction accepted while the older one traps is dropped here
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_valid <= 1'b0;
                    s1_bad   <= 1'b0;
                    s1_instr <= '0;
                end else begin
                    s1_valid <= accept & ~fire;
                    if (accept) begin
                        s1_instr <= INSTR;
                        s1_bad   <= dec_bad;
                    end
                end
            end

            assign fire      = corerunning & s1_valid & s1_bad;
            assign fire_word = s1_instr;
        end else begin : g_direct
            assign fire      = accept & dec_bad;
            assign fire_word = INSTR;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fire) state_nxt = PEND;
            PEND:    if (trap_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ready        = (state != PEND);
    assign trap_pending = (state == PEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal       <= 1'b0;
            trap_instr    <= '0;
            illegal_count <= '0;
            count_ovf     <= 1'b0;
        end else begin
            illegal <= fire;
            if (fire) begin
                trap_instr <= fire_word;
                if (&illegal_count)
                    count_ovf <= 1'b1;
                else
                    illegal_count <= illegal_count + {{(CNTW-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
